// File: rtl/uart_tx_fifo.sv
// UART transmitter with a FIFO-fed frame engine: DATA_BITS 5..9, optional even/odd parity, 1 or 2 stop bits.
// Latency: a push into an empty idle block drives the start bit from the next edge; frames run back-to-back.
// Backpressure: ready drops while the FIFO is full or reset_n is low; the producer holds valid until accepted.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 12000000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset_n,
    input  logic [DATA_BITS-1:0]          data,
    input  logic                          valid,
    output logic                          ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BIT_W = 4;

    if (DIV < 2 || DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
        $error("uart_tx_fifo: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t               state;
    logic [DIV_W-1:0]     div_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;
    logic [DATA_BITS-1:0] head;
    logic                 push;
    logic                 pop;
    logic                 period_end;
    logic                 last_stop;
    logic                 fifo_nonempty;

    assign head          = mem[rd_ptr];
    assign fifo_nonempty = (count != '0);
    assign ready         = reset_n && (count != CNT_W'(FIFO_DEPTH));
    assign push          = valid && ready;
    assign period_end    = (div_cnt == DIV_W'(DIV - 1));
    assign last_stop     = (bit_cnt == BIT_W'(STOP_BITS - 1));
    // The head leaves the FIFO either from idle or exactly at the last stop-bit edge,
    // so a queued word follows the previous stop bit with no idle cycle.
    assign pop           = fifo_nonempty &&
                           ((state == S_IDLE) || (state == S_STOP && period_end && last_stop));
    assign busy          = (state != S_IDLE) || fifo_nonempty;
    assign fifo_count    = count;

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            tx      <= 1'b1;
            div_cnt <= '0;
            bit_cnt <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                end
                S_START: begin
                    if (period_end) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= S_DATA;
                        tx      <= shift[0];
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_DATA: begin
                    if (period_end) begin
                        div_cnt <= '0;
                        if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                            bit_cnt <= '0;
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                                tx    <= par_bit;
                            end else begin
                                state <= S_STOP;
                                tx    <= 1'b1;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            shift   <= shift >> 1;
                            tx      <= shift[1];
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_PARITY: begin
                    if (period_end) begin
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        state   <= S_STOP;
                        tx      <= 1'b1;
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                S_STOP: begin
                    if (period_end) begin
                        div_cnt <= '0;
                        if (last_stop) begin
                            bit_cnt <= '0;
                            state   <= S_IDLE;
                            tx      <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_W'(1);
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    tx    <= 1'b1;
                end
            endcase

            // Frame load overrides the state-case assignments above on a pop edge.
            if (pop) begin
                shift   <= head;
                par_bit <= (PARITY == 2) ? ~^head : ^head;
                div_cnt <= '0;
                bit_cnt <= '0;
                state   <= S_START;
                tx      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: 8N1/8E1/8O1/7E2 framing, FIFO backpressure, back-to-back frames, reset abort.
module tb_uart_tx_fifo;

    logic clock;
    logic reset_n;
    int   cyc;
    int   n_checks;
    int   n_fail;

    // 8N1, DIV=10
    logic [7:0] a_data;
    logic       a_valid, a_ready, a_tx, a_busy;
    logic [2:0] a_cnt;
    // 8E1 / 8O1 / 7E2, DIV=10, driven together
    logic [7:0] p_data;
    logic [6:0] d_data;
    logic       p_valid;
    logic       b_ready, b_tx, b_busy, c_ready, c_tx, c_busy, d_ready, d_tx, d_busy;
    logic [2:0] b_cnt, c_cnt, d_cnt;
    // default parameters, DIV=104
    logic [7:0] e_data;
    logic       e_valid, e_ready, e_tx, e_busy;
    logic [2:0] e_cnt;

    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100)) u_a (
        .clock(clock), .reset_n(reset_n), .data(a_data), .valid(a_valid), .ready(a_ready),
        .tx(a_tx), .busy(a_busy), .fifo_count(a_cnt));
    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .PARITY(1)) u_b (
        .clock(clock), .reset_n(reset_n), .data(p_data), .valid(p_valid), .ready(b_ready),
        .tx(b_tx), .busy(b_busy), .fifo_count(b_cnt));
    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .PARITY(2)) u_c (
        .clock(clock), .reset_n(reset_n), .data(p_data), .valid(p_valid), .ready(c_ready),
        .tx(c_tx), .busy(c_busy), .fifo_count(c_cnt));
    uart_tx_fifo #(.CLK_FREQ(1000), .BAUD(100), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) u_d (
        .clock(clock), .reset_n(reset_n), .data(d_data), .valid(p_valid), .ready(d_ready),
        .tx(d_tx), .busy(d_busy), .fifo_count(d_cnt));
    uart_tx_fifo u_e (
        .clock(clock), .reset_n(reset_n), .data(e_data), .valid(e_valid), .ready(e_ready),
        .tx(e_tx), .busy(e_busy), .fifo_count(e_cnt));

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clock);
            cyc++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic push_a(input logic [7:0] w, input int budget, output int acc);
        acc     = -1;
        a_valid = 1'b1;
        a_data  = w;
        for (int i = 0; i < budget; i++) begin
            if (a_ready) begin
                tick();
                acc = cyc;
                break;
            end
            tick();
        end
        a_valid = 1'b0;
    endtask

    // Receiver on the 8N1 line: records {stop_bit, data} and the cycle of the start bit's first sample.
    int rx_words[$];
    int rx_start[$];

    initial begin : rx_mon
        logic       prev;
        logic       in_frame;
        logic [7:0] w;
        int         t;
        int         st;
        prev = 1'b1; in_frame = 1'b0; w = '0; t = 0; st = 0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                in_frame = 1'b0;
                prev     = 1'b1;
            end else if (!in_frame) begin
                if (prev && a_tx == 1'b0) begin
                    in_frame = 1'b1;
                    t        = 0;
                    st       = cyc;
                end
                prev = a_tx;
            end else begin
                t++;
                if (t >= 15 && t <= 85 && (t - 15) % 10 == 0) w[(t - 15) / 10] = a_tx;
                if (t == 95) begin
                    rx_words.push_back(int'({a_tx, w}));
                    rx_start.push_back(st);
                    in_frame = 1'b0;
                    prev     = 1'b1;
                end
            end
        end
    end

    task automatic wait_rx(input int n, input string tag);
        for (int i = 0; i < 1000 && rx_words.size() < n; i++) tick();
        check(tag, rx_words.size(), n);
    endtask

    task automatic wait_a_idle(input string tag);
        for (int i = 0; i < 1200 && a_busy; i++) tick();
        check(tag, a_busy, 1'b0);
    endtask

    logic [7:0] v55;
    logic [6:0] v41;
    logic [7:0] w3 [6];
    int         acc [6];
    int         e0, t0, t1;

    initial begin
        n_checks = 0; n_fail = 0;
        reset_n = 1'b0;
        a_valid = 1'b0; a_data = '0; p_valid = 1'b0; p_data = '0; d_data = '0;
        e_valid = 1'b0; e_data = '0;
        v55 = 8'h55; v41 = 7'h41;
        w3[0] = 8'hA1; w3[1] = 8'h52; w3[2] = 8'hC3; w3[3] = 8'h34; w3[4] = 8'hE5; w3[5] = 8'h96;
        #1;
        check("rst_ready_low", a_ready, 1'b0);
        tick();
        tick();
        check("rst_tx", a_tx, 1'b1);
        check("rst_busy", a_busy, 1'b0);
        check("rst_cnt", a_cnt, 3'd0);
        check("rst_e_tx", e_tx, 1'b1);
        reset_n = 1'b1;
        #1;
        check("rst_ready_high", a_ready, 1'b1);
        tick();

        // 8N1 cycle-exact frame plus parity variants, all pushed on the same edge E
        a_valid = 1'b1; a_data = v55; p_valid = 1'b1; p_data = v55; d_data = v41;
        tick();
        a_valid = 1'b0; p_valid = 1'b0;
        check("t1_tx_E", a_tx, 1'b1);
        check("t1_cnt_E", a_cnt, 3'd1);
        for (int k = 1; k <= 111; k++) begin
            tick();
            if (k <= 101) begin
                if (k <= 10)      check("t1_start", a_tx, 1'b0);
                else if (k <= 90) check("t1_data", a_tx, v55[(k - 11) / 10]);
                else              check("t1_stop", a_tx, 1'b1);
            end
            if (k == 1)   check("t1_cnt_pop", a_cnt, 3'd0);
            if (k == 100) check("t1_busy_100", a_busy, 1'b1);
            if (k == 101) check("t1_busy_101", a_busy, 1'b0);
            if (k == 95)  begin check("t2_even_par", b_tx, 1'b0); check("t2_odd_par", c_tx, 1'b1); end
            if (k == 105) begin check("t2_even_stop", b_tx, 1'b1); check("t2_odd_stop", c_tx, 1'b1); end
            if (k == 25)  check("t2_7e2_bit1", d_tx, 1'b0);
            if (k == 75)  check("t2_7e2_bit6", d_tx, 1'b1);
            if (k == 85)  check("t2_7e2_par", d_tx, 1'b0);
            if (k == 95)  check("t2_7e2_stop1", d_tx, 1'b1);
            if (k == 105) check("t2_7e2_stop2", d_tx, 1'b1);
            if (k == 110) begin check("t2_7e2_busy_110", d_busy, 1'b1); check("t2_8e1_busy_110", b_busy, 1'b1); end
            if (k == 111) begin check("t2_7e2_busy_111", d_busy, 1'b0); check("t2_8e1_busy_111", b_busy, 1'b0); end
        end

        // six words back-to-back into a depth-4 FIFO
        rx_words.delete(); rx_start.delete();
        for (int i = 0; i < 6; i++) begin
            push_a(w3[i], 200, acc[i]);
            if (i == 4) check("t3_ready_full", a_ready, 1'b0);
        end
        for (int i = 1; i < 5; i++) check("t3_acc_edge", acc[i] - acc[0], i);
        check("t3_sixth_edge", acc[5] - acc[0], 102);
        wait_rx(6, "t3_frames");
        for (int i = 0; i < 6 && i < rx_words.size(); i++) begin
            check("t3_word", rx_words[i], int'({1'b1, w3[i]}));
            check("t3_start", rx_start[i] - acc[0], 1 + 100 * i);
        end
        wait_a_idle("t3_idle");

        // push and pop on the same edge with two queued
        tick();
        rx_words.delete(); rx_start.delete();
        for (int i = 0; i < 3; i++) push_a(w3[5 - i], 20, acc[i]);
        check("t4_acc2", acc[2] - acc[0], 2);
        for (int i = 0; i < 98; i++) tick();
        check("t4_cnt_before", a_cnt, 3'd2);
        a_valid = 1'b1; a_data = 8'h3C;
        check("t4_ready", a_ready, 1'b1);
        tick();
        a_valid = 1'b0;
        check("t4_cnt_after", a_cnt, 3'd2);
        check("t4_restart", a_tx, 1'b0);
        wait_rx(4, "t4_frames");
        for (int i = 0; i < 3 && i < rx_words.size(); i++) check("t4_order", rx_words[i], int'({1'b1, w3[5 - i]}));
        if (rx_words.size() >= 4) check("t4_last", rx_words[3], 32'h13C);
        wait_a_idle("t4_idle");

        // valid held against a full FIFO must not overwrite anything
        tick();
        rx_words.delete(); rx_start.delete();
        for (int i = 0; i < 5; i++) push_a(w3[i], 20, acc[i]);
        a_valid = 1'b1; a_data = 8'hEE;
        for (int i = 0; i < 20; i++) tick();
        check("t6_ready_held", a_ready, 1'b0);
        check("t6_cnt_full", a_cnt, 3'd4);
        a_valid = 1'b0;
        wait_rx(5, "t6_frames");
        for (int i = 0; i < 5 && i < rx_words.size(); i++) check("t6_word", rx_words[i], int'({1'b1, w3[i]}));
        wait_a_idle("t6_idle");
        for (int i = 0; i < 150; i++) tick();
        check("t6_no_extra", rx_words.size(), 5);

        // one-cycle reset in the middle of a data bit with three queued
        for (int i = 0; i < 4; i++) push_a(w3[i], 20, acc[i]);
        for (int i = 0; i < 37; i++) tick();
        check("t5_cnt_pre", a_cnt, 3'd3);
        check("t5_tx_mid", a_tx, w3[0][2]);
        reset_n = 1'b0;
        a_valid = 1'b1; a_data = 8'h77;
        #1;
        check("t5_ready_rst", a_ready, 1'b0);
        tick();
        check("t5_tx", a_tx, 1'b1);
        check("t5_cnt", a_cnt, 3'd0);
        check("t5_busy", a_busy, 1'b0);
        reset_n = 1'b1;
        a_valid = 1'b0;
        #1;
        check("t5_ready_after", a_ready, 1'b1);
        tick();
        check("t5_tx_next", a_tx, 1'b1);
        check("t5_busy_next", a_busy, 1'b0);

        // default parameters: measure the bit period
        e_valid = 1'b1; e_data = 8'h01;
        tick();
        e_valid = 1'b0;
        e0 = cyc;
        for (int i = 0; i < 20 && e_tx; i++) tick();
        check("e_start_edge", cyc - e0, 1);
        t0 = cyc;
        for (int i = 0; i < 300 && !e_tx; i++) tick();
        check("e_start_len", cyc - t0, 104);
        t1 = cyc;
        for (int i = 0; i < 300 && e_tx; i++) tick();
        check("e_bit0_len", cyc - t1, 104);
        for (int i = 0; i < 1200 && e_busy; i++) tick();
        check("e_frame_len", cyc - e0, 1041);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
